// File: rtl/sdr_wb_arbiter_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : sdr_wb_arbiter_pkg                                               |
// | Purpose  : Wishbone cycle/burst encodings and arbiter state encodings.      |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package sdr_wb_arbiter_pkg;

  localparam logic [2:0] C_CTI_CLASSIC    = 3'b000;
  localparam logic [2:0] C_CTI_INCR       = 3'b010;
  localparam logic [2:0] C_CTI_ENDOFBURST = 3'b111;

  localparam logic [1:0] C_BTE_LINEAR = 2'b00;
  localparam logic [1:0] C_BTE_BEAT4  = 2'b01;
  localparam logic [1:0] C_BTE_BEAT8  = 2'b10;
  localparam logic [1:0] C_BTE_BEAT16 = 2'b11;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  // An ack on a classic or end-of-burst cycle closes a transfer, so the
  // grant may move without splitting a burst.
  function automatic logic is_boundary(input logic [2:0] cti);
    return (cti == C_CTI_CLASSIC) || (cti == C_CTI_ENDOFBURST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdr_wb_arb_hold_cnt.sv
// +----------------------------------------------------------------------------+
// | Module   : sdr_wb_arb_hold_cnt                                              |
// | Purpose  : Saturating grant-hold counter with clear, enable, terminal flag. |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdr_wb_arb_hold_cnt #(
  parameter int MAX_HOLD   = 64,
  parameter int HOLD_WIDTH = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_terminal
);

  localparam logic [HOLD_WIDTH-1:0] C_MAX = HOLD_WIDTH'(MAX_HOLD);

  logic [HOLD_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_terminal = (r_cnt == C_MAX);

endmodule

`default_nettype wire

// File: rtl/sdr_wb_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : sdr_wb_arbiter                                                   |
// | Purpose  : Two-master Wishbone B3 arbiter in front of the SDR SDRAM ctrl.   |
// |            SDR_WB_ARB_RR_EN selects round-robin ties (else fixed priority). |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdr_wb_arbiter
  import sdr_wb_arbiter_pkg::*;
#(
  parameter int ADR_WIDTH  = 24,
  parameter int MAX_HOLD   = 64,
  parameter int HOLD_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [31:0]          m0_dat_i,
  input  logic [ADR_WIDTH-1:0] m0_adr_i,
  input  logic [3:0]           m0_sel_i,
  input  logic [2:0]           m0_cti_i,
  input  logic [1:0]           m0_bte_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  output logic [31:0]          m0_dat_o,
  output logic                 m0_ack_o,

  input  logic [31:0]          m1_dat_i,
  input  logic [ADR_WIDTH-1:0] m1_adr_i,
  input  logic [3:0]           m1_sel_i,
  input  logic [2:0]           m1_cti_i,
  input  logic [1:0]           m1_bte_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  output logic [31:0]          m1_dat_o,
  output logic                 m1_ack_o,

  output logic [31:0]          s_dat_o,
  output logic [ADR_WIDTH-1:0] s_adr_o,
  output logic [3:0]           s_sel_o,
  output logic [2:0]           s_cti_o,
  output logic [1:0]           s_bte_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       w_hold_term;
  logic       w_hold_clr;
  logic       w_hold_en;
  logic       w_tie_gnt1;

`ifdef SDR_WB_ARB_RR_EN
  localparam logic C_PREEMPT_PORT0 = 1'b1;

  logic r_last_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= 1'b1;
    end else if ((r_state == ARB_GNT0) && (w_state_nxt != ARB_GNT0)) begin
      r_last_gnt <= 1'b0;
    end else if ((r_state == ARB_GNT1) && (w_state_nxt != ARB_GNT1)) begin
      r_last_gnt <= 1'b1;
    end
  end

  assign w_tie_gnt1 = ~r_last_gnt;
`else
  // Port 0 has fixed priority: it wins ties and is never pre-empted.
  localparam logic C_PREEMPT_PORT0 = 1'b0;

  assign w_tie_gnt1 = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_state_nxt = w_tie_gnt1 ? ARB_GNT1 : ARB_GNT0;
        end else if (m0_cyc_i) begin
          w_state_nxt = ARB_GNT0;
        end else if (m1_cyc_i) begin
          w_state_nxt = ARB_GNT1;
        end
      end
      ARB_GNT0: begin
        if (!m0_cyc_i) begin
          w_state_nxt = m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
        end else if (C_PREEMPT_PORT0 && w_hold_term && m1_cyc_i &&
                     s_ack_i && is_boundary(m0_cti_i)) begin
          w_state_nxt = ARB_GNT1;
        end
      end
      ARB_GNT1: begin
        if (!m1_cyc_i) begin
          w_state_nxt = m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
        end else if (w_hold_term && m0_cyc_i && s_ack_i && is_boundary(m1_cti_i)) begin
          w_state_nxt = ARB_GNT0;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign w_hold_clr = (w_state_nxt != r_state);
  assign w_hold_en  = (r_state != ARB_IDLE);

  sdr_wb_arb_hold_cnt #(
    .MAX_HOLD   (MAX_HOLD),
    .HOLD_WIDTH (HOLD_WIDTH)
  ) u_hold_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_hold_clr),
    .i_en       (w_hold_en),
    .o_terminal (w_hold_term)
  );

  // Slave bus follows the registered grant; a pre-empted owner is thereby
  // cut off the slave until it is granted again.
  always_comb begin
    s_dat_o  = '0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = C_CTI_CLASSIC;
    s_bte_o  = C_BTE_LINEAR;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (r_state)
      ARB_GNT0: begin
        s_dat_o  = m0_dat_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_ack_o = s_ack_i;
      end
      ARB_GNT1: begin
        s_dat_o  = m1_dat_i;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_ack_o = s_ack_i;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

`default_nettype wire
